halfband_filter: RTL and testbench

//  Parallel 8-lane halfband low-pass FIR for the ADC datapath, 16-bit signed samples.

---
 rtl/halfband_pkg.sv | 48 ++++
 rtl/halfband_lane.sv | 71 +++++++
 rtl/halfband_filter.sv | 64 ++++++
 tb/tb_halfband_filter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halfband_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : halfband_pkg                                                    |
// | Purpose  : Types, coefficients and rounding/clip helper for halfband_filter|
// |            (HALFBAND_SAT_EN selects saturation instead of wrap)            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package halfband_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int SAMPLE_W    = 16;
  localparam int NLANES      = 8;
  localparam int NTAPS       = 11;
  localparam int ACC_W       = 35;
  localparam int ROUND_SHIFT = 15;

  // History depth needed so every lane sees its full 11-sample window.
  localparam int HIST_LEN = NTAPS - 1;
  localparam int WIN_LEN  = HIST_LEN + NLANES;

  localparam sample_t C_CTR = 16'sd16384;
  localparam sample_t C1    = 16'sd9984;
  localparam sample_t C3    = -16'sd2304;
  localparam sample_t C5    = 16'sd512;

  localparam sample_t H [NTAPS] = '{C5, 16'sd0, C3, 16'sd0, C1, C_CTR,
                                    C1, 16'sd0, C3, 16'sd0, C5};

  // Takes the already-biased accumulator; shifts to Q0 and reduces to 16 bits.
  function automatic sample_t round_and_clip(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] q;
    q = acc >>> ROUND_SHIFT;
`ifdef HALFBAND_SAT_EN
    if (q > $signed(ACC_W'(32'sd32767))) begin
      return 16'sh7fff;
    end else if (q < $signed(ACC_W'(-32'sd32768))) begin
      return 16'sh8000;
    end else begin
      return sample_t'(q);
    end
`else
    return sample_t'(q);
`endif
  endfunction

endpackage : halfband_pkg
`default_nettype wire

// File: rtl/halfband_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : halfband_lane                                                   |
// | Purpose  : One output lane: symmetric pre-add, 4 products, sum/round/clip  |
// |            (clip behaviour follows HALFBAND_SAT_EN)                        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module halfband_lane
  import halfband_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_en,
  input  sample_t i_x0,
  input  sample_t i_x2,
  input  sample_t i_x4,
  input  sample_t i_x5,
  input  sample_t i_x6,
  input  sample_t i_x8,
  input  sample_t i_x10,
  output sample_t o_y
);

  localparam int PRE_W  = SAMPLE_W + 1;
  localparam int PROD_W = PRE_W + SAMPLE_W;
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (ROUND_SHIFT - 1));

  logic signed [PRE_W-1:0]  w_pre1;
  logic signed [PRE_W-1:0]  w_pre3;
  logic signed [PRE_W-1:0]  w_pre5;
  logic signed [PROD_W-1:0] r_prod_ctr;
  logic signed [PROD_W-1:0] r_prod1;
  logic signed [PROD_W-1:0] r_prod3;
  logic signed [PROD_W-1:0] r_prod5;
  logic signed [ACC_W-1:0]  w_acc;
  sample_t                  r_y;

  // Equal taps around the centre share one multiplier.
  assign w_pre1 = PRE_W'(i_x4) + PRE_W'(i_x6);
  assign w_pre3 = PRE_W'(i_x2) + PRE_W'(i_x8);
  assign w_pre5 = PRE_W'(i_x0) + PRE_W'(i_x10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_ctr <= '0;
      r_prod1    <= '0;
      r_prod3    <= '0;
      r_prod5    <= '0;
    end else if (i_en) begin
      r_prod_ctr <= PROD_W'(i_x5)   * PROD_W'(H[5]);
      r_prod1    <= PROD_W'(w_pre1) * PROD_W'(H[4]);
      r_prod3    <= PROD_W'(w_pre3) * PROD_W'(H[2]);
      r_prod5    <= PROD_W'(w_pre5) * PROD_W'(H[0]);
    end
  end

  assign w_acc = ACC_W'(r_prod_ctr) + ACC_W'(r_prod1) + ACC_W'(r_prod3)
               + ACC_W'(r_prod5) + ROUND_BIAS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
    end else if (i_en) begin
      r_y <= round_and_clip(w_acc);
    end
  end

  assign o_y = r_y;

endmodule : halfband_lane
`default_nettype wire

// File: rtl/halfband_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : halfband_filter                                                 |
// | Purpose  : 8-lane parallel 11-tap halfband FIR, 3-beat latency, tvalid=CE  |
// |            Define HALFBAND_SAT_EN to saturate instead of wrap on overflow  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module halfband_filter
  import halfband_pkg::*;
(
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NLANES*SAMPLE_W-1:0]   s_axis_data_tdata,
  input  logic                         s_axis_data_tvalid,
  output logic [NLANES*SAMPLE_W-1:0]   m_axis_data_tdata
);

  sample_t r_cur  [NLANES];
  sample_t r_hist [HIST_LEN];
  sample_t w_win  [WIN_LEN];
  sample_t w_y    [NLANES];

  // Window index HIST_LEN+k is the current sample of lane k; lower indices are older.
  generate
    for (genvar i = 0; i < HIST_LEN; i++) begin : g_win_hist
      assign w_win[i] = r_hist[i];
    end
    for (genvar i = 0; i < NLANES; i++) begin : g_win_cur
      assign w_win[HIST_LEN + i] = r_cur[i];
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < HIST_LEN; i++) r_hist[i] <= '0;
      for (int i = 0; i < NLANES; i++)   r_cur[i]  <= '0;
    end else if (s_axis_data_tvalid) begin
      for (int i = 0; i < HIST_LEN; i++) r_hist[i] <= w_win[i + NLANES];
      for (int i = 0; i < NLANES; i++)
        r_cur[i] <= sample_t'(s_axis_data_tdata[SAMPLE_W*i +: SAMPLE_W]);
    end
  end

  generate
    for (genvar k = 0; k < NLANES; k++) begin : g_lane
      halfband_lane u_lane (
        .clk   (aclk),
        .rst_n (aresetn),
        .i_en  (s_axis_data_tvalid),
        .i_x0  (w_win[HIST_LEN + k]),
        .i_x2  (w_win[HIST_LEN + k - 2]),
        .i_x4  (w_win[HIST_LEN + k - 4]),
        .i_x5  (w_win[HIST_LEN + k - 5]),
        .i_x6  (w_win[HIST_LEN + k - 6]),
        .i_x8  (w_win[HIST_LEN + k - 8]),
        .i_x10 (w_win[HIST_LEN + k - 10]),
        .o_y   (w_y[k])
      );
      assign m_axis_data_tdata[SAMPLE_W*k +: SAMPLE_W] = w_y[k];
    end
  endgenerate

endmodule : halfband_filter
`default_nettype wire

// File: tb/tb_halfband_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_halfband_filter                                              |
// | Purpose  : Self-checking bench for halfband_filter against a sample model  |
// |            (model honours HALFBAND_SAT_EN the same way as the design)      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_halfband_filter;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         tvalid = 1'b0;
  logic [127:0] tdata = '0;
  logic [127:0] tout;

  int total = 0;
  int bad   = 0;

  // Accepted input samples since the last reset, oldest first.
  int xs[$];
  int nedge = 0;

  localparam int HT [11] = '{512, 0, -2304, 0, 9984, 16384, 9984, 0, -2304, 0, 512};

  halfband_filter dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tdata  (tdata),
    .s_axis_data_tvalid (tvalid),
    .m_axis_data_tdata  (tout)
  );

  always #5 aclk = ~aclk;

  function automatic int ref_y(input int m);
    longint acc;
    longint r;
    logic [63:0] rb;
    acc = 0;
    for (int j = 0; j < 11; j++)
      if (m - j >= 0) acc += longint'(HT[j]) * longint'(xs[m - j]);
    r = (acc + 64'sd16384) >>> 15;
`ifdef HALFBAND_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
`else
    rb = r;
    return int'($signed(rb[15:0]));
`endif
  endfunction

  // Output visible after the n-th enabled edge belongs to input beat n-3.
  function automatic logic [127:0] ref_out();
    logic [127:0] v;
    int b;
    v = '0;
    b = nedge - 3;
    if (b >= 0)
      for (int k = 0; k < 8; k++) v[16*k +: 16] = 16'(ref_y(8*b + k));
    return v;
  endfunction

  function automatic logic [127:0] pack8(input int v [8]);
    logic [127:0] p;
    for (int k = 0; k < 8; k++) p[16*k +: 16] = 16'(v[k]);
    return p;
  endfunction

  task automatic step(input logic v, input logic [127:0] d);
    tvalid = v;
    tdata  = d;
    @(posedge aclk);
    if (v) begin
      for (int k = 0; k < 8; k++) xs.push_back(int'($signed(d[16*k +: 16])));
      nedge++;
    end
    #1;
  endtask

  task automatic do_reset();
    tvalid  = 1'b0;
    aresetn = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    xs.delete();
    nedge = 0;
  endtask

  function automatic logic [127:0] rand_beat();
    logic [127:0] d;
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 7))
        0:       d[16*k +: 16] = 16'h7fff;
        1:       d[16*k +: 16] = 16'h8000;
        default: d[16*k +: 16] = 16'($urandom);
      endcase
    end
    return d;
  endfunction

  task automatic test_reset();
    logic [127:0] want;
    aresetn = 1'b0;
    tvalid  = 1'b1;
    tdata   = {8{16'h1234}};
    repeat (3) @(posedge aclk);
    #1;
    total++;
    if (tout !== '0) begin
      bad++;
      $display("FAIL reset_hold: got %h want 0", tout);
    end
    aresetn = 1'b1;
    xs.delete();
    nedge = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, '0);
      total++;
      if (tout !== '0) begin
        bad++;
        $display("FAIL reset_release beat %0d: got %h want 0", i, tout);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rand_beat());
      want = ref_out();
      total++;
      if (tout !== want) begin
        bad++;
        $display("FAIL reset_prestream beat %0d: got %h want %h", i, tout, want);
      end
    end
    aresetn = 1'b0;
    #2;
    total++;
    if (tout !== '0) begin
      bad++;
      $display("FAIL reset_async: got %h want 0", tout);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    xs.delete();
    nedge = 0;
  endtask

  task automatic test_impulse();
    logic [127:0] want;
    int imp3 [8] = '{16, 0, -70, 0, 305, 500, 305, 0};
    int imp4 [8] = '{-70, 0, 16, 0, 0, 0, 0, 0};
    do_reset();
    step(1'b1, 128'd1000);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, '0);
      want = ref_out();
      total++;
      if (tout !== want) begin
        bad++;
        $display("FAIL impulse_model edge %0d: got %h want %h", nedge, tout, want);
      end
      if (nedge == 3) begin
        total++;
        if (tout !== pack8(imp3)) begin
          bad++;
          $display("FAIL impulse_T3: got %h want %h", tout, pack8(imp3));
        end
      end
      if (nedge == 4) begin
        total++;
        if (tout !== pack8(imp4)) begin
          bad++;
          $display("FAIL impulse_T4: got %h want %h", tout, pack8(imp4));
        end
      end
    end
  endtask

  task automatic test_dc();
    logic [127:0] want;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, {8{16'h8000}});
      want = ref_out();
      total++;
      if (tout !== want) begin
        bad++;
        $display("FAIL dc_neg_model beat %0d: got %h want %h", i, tout, want);
      end
    end
    total++;
    if (tout !== {8{16'h8000}}) begin
      bad++;
      $display("FAIL dc_neg_steady: got %h want %h", tout, {8{16'h8000}});
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, {8{16'd1000}});
      want = ref_out();
      total++;
      if (tout !== want) begin
        bad++;
        $display("FAIL dc_1000_model beat %0d: got %h want %h", i, tout, want);
      end
    end
    total++;
    if (tout !== {8{16'd1000}}) begin
      bad++;
      $display("FAIL dc_1000_steady: got %h want %h", tout, {8{16'd1000}});
    end
  endtask

  task automatic test_stall();
    logic [127:0] want;
    logic [127:0] held;
    int imp3 [8] = '{16, 0, -70, 0, 305, 500, 305, 0};
    do_reset();
    step(1'b1, 128'd1000);
    for (int i = 0; i < 5; i++) begin
      held = tout;
      step(1'b0, rand_beat());
      total++;
      if (tout !== held) begin
        bad++;
        $display("FAIL stall_hold cycle %0d: got %h want %h", i, tout, held);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, '0);
      want = ref_out();
      total++;
      if (tout !== want) begin
        bad++;
        $display("FAIL stall_model edge %0d: got %h want %h", nedge, tout, want);
      end
      if (nedge == 3) begin
        total++;
        if (tout !== pack8(imp3)) begin
          bad++;
          $display("FAIL stall_T3: got %h want %h", tout, pack8(imp3));
        end
        for (int s = 0; s < 3; s++) begin
          step(1'b0, rand_beat());
          total++;
          if (tout !== pack8(imp3)) begin
            bad++;
            $display("FAIL stall_hold_nonzero cycle %0d: got %h want %h", s, tout, pack8(imp3));
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [127:0] want;
    logic [127:0] b0;
    logic [127:0] b1;
    logic signed [15:0] lane2;
    b0 = {8{16'h7fff}};
    b0[32 +: 16] = 16'h8000;
    b1 = {8{16'h7fff}};
    b1[0 +: 16] = 16'h8000;
    do_reset();
    step(1'b1, b0);
    step(1'b1, b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, '0);
      want = ref_out();
      total++;
      if (tout !== want) begin
        bad++;
        $display("FAIL overflow_model edge %0d: got %h want %h", nedge, tout, want);
      end
      if (nedge == 4) begin
        lane2 = tout[32 +: 16];
        total++;
`ifdef HALFBAND_SAT_EN
        if (lane2 !== 16'sd32767) begin
          bad++;
          $display("FAIL overflow_sat_lane2: got %0d want 32767", lane2);
        end
`else
        if (lane2 !== -16'sd23553) begin
          bad++;
          $display("FAIL overflow_wrap_lane2: got %0d want -23553", lane2);
        end
`endif
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] want;
    logic v;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) do_reset();
      v = ($urandom_range(0, 3) != 0);
      step(v, rand_beat());
      want = ref_out();
      total++;
      if (tout !== want) begin
        bad++;
        if (bad < 20)
          $display("FAIL random beat %0d: got %h want %h", i, tout, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_stall();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_halfband_filter
`default_nettype wire
